// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the tamagotchi button front end: button indices,
// long-press FSM state encoding and default cycle counts for a 50 MHz clock.
package tamagotchi_pkg;

    // Index of each conditioned input inside the front end's input vector
    localparam int unsigned SALUD     = 0;
    localparam int unsigned ENERGIA   = 1;
    localparam int unsigned HAMBRE    = 2;
    localparam int unsigned DIVERSION = 3;
    localparam int unsigned RESET_IDX = 4;
    localparam int unsigned TEST_IDX  = 5;
    localparam int unsigned LIGHT_IDX = 6;

    localparam int unsigned N_ACTION  = 4;
    localparam int unsigned N_INPUTS  = 7;

    // Default timing at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 500000;     // 10 ms
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 250000000;  // 5 s
    localparam int unsigned DEF_REPEAT_CYCLES     = 25000000;   // 0.5 s

    // Long-press detector states
    typedef enum logic [1:0] {
        LP_IDLE  = 2'd0,
        LP_COUNT = 2'd1,
        LP_FIRED = 2'd2
    } lp_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One input channel: polarity normalisation, two-flop synchroniser and a
// debouncer that only accepts a new level after DEBOUNCE_CYCLES consecutive
// cycles of disagreement with the current stable level.
// The stable output is 1 for "pressed" / "lit" regardless of pin polarity.
module btn_debounce
    import tamagotchi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             level;
    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign level = ACTIVE_LOW ? ~raw : raw;

    // Two-flop synchroniser; reset value is the released/dark level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= level;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive disagreeing cycles; flip stable at terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (sync2_reg == stable_reg) begin
            cnt_reg    <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
        end else begin
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/tamagotchi_btn_front.sv
// Button/light-sensor front end for tamagotchi_fsm.
// Debounces seven board inputs, turns action-button presses into single
// prioritised pulses, and turns a long hold of reset/test into one pulse.
// Optional feature macro: BTN_AUTOREPEAT_EN (held action buttons re-pulse).
module tamagotchi_btn_front
    import tamagotchi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_salud,
    input  logic raw_energia,
    input  logic raw_hambre,
    input  logic raw_diversion,
    input  logic raw_reset,
    input  logic raw_test,
    input  logic raw_light,
    output logic btn_salud,
    output logic btn_energia,
    output logic btn_hambre,
    output logic btn_diversion,
    output logic btn_reset,
    output logic btn_test,
    output logic ledsign
);

    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    genvar gi;

    // Zero-length timings would make the counters meaningless
    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_cfg_check
        $error("tamagotchi_btn_front: cycle parameters must be at least 1");
    end

    logic [N_INPUTS-1:0] raw_vec;
    logic [N_INPUTS-1:0] stable;
    logic [N_ACTION-1:0] stable_prev_reg;
    logic [N_ACTION-1:0] press_evt;
    logic [N_ACTION-1:0] act_grant;
    logic [N_ACTION-1:0] act_pulse_reg;
    logic [1:0]          lp_fire;
    logic                btn_reset_reg;
    logic                btn_test_reg;
    logic                ledsign_reg;
    logic                suppress;

    assign raw_vec = {raw_light, raw_test, raw_reset, raw_diversion,
                      raw_hambre, raw_energia, raw_salud};

    for (gi = 0; gi < N_INPUTS; gi++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_vec[gi]),
            .stable (stable[gi])
        );
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned FIRST_REPEAT_CYCLES = (LONG_PRESS_CYCLES / 5 > 0) ? LONG_PRESS_CYCLES / 5 : 1;
    localparam int unsigned RPT_MAX = (FIRST_REPEAT_CYCLES > REPEAT_CYCLES) ? FIRST_REPEAT_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] FIRST_LAST = RPT_W'(FIRST_REPEAT_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_CYCLES - 1);

    for (gi = 0; gi < N_ACTION; gi++) begin : g_rpt
        logic [RPT_W-1:0] rpt_cnt_reg;
        logic             rpt_armed_reg;
        logic             rpt_hit;

        assign rpt_hit = stable[gi] &&
                         (rpt_cnt_reg == (rpt_armed_reg ? RPT_LAST : FIRST_LAST));

        // Hold timer: first repeat after the long initial delay, then periodic
        always_ff @(posedge clk) begin
            if (rst || !stable[gi]) begin
                rpt_cnt_reg   <= '0;
                rpt_armed_reg <= 1'b0;
            end else if (rpt_hit) begin
                rpt_cnt_reg   <= '0;
                rpt_armed_reg <= 1'b1;
            end else begin
                rpt_cnt_reg   <= rpt_cnt_reg + 1'b1;
            end
        end

        assign press_evt[gi] = (stable[gi] & ~stable_prev_reg[gi]) | rpt_hit;
    end
`else
    for (gi = 0; gi < N_ACTION; gi++) begin : g_evt
        assign press_evt[gi] = stable[gi] & ~stable_prev_reg[gi];
    end
`endif

    // A held reset or test button masks every action button
    assign suppress = stable[RESET_IDX] | stable[TEST_IDX];

    // Fixed priority; losing press events are dropped
    always_comb begin
        act_grant = '0;
        if (!suppress) begin
            if (press_evt[SALUD])          act_grant[SALUD]     = 1'b1;
            else if (press_evt[ENERGIA])   act_grant[ENERGIA]   = 1'b1;
            else if (press_evt[HAMBRE])    act_grant[HAMBRE]    = 1'b1;
            else if (press_evt[DIVERSION]) act_grant[DIVERSION] = 1'b1;
        end
    end

    // Long-press detectors: index 0 watches reset, index 1 watches test
    for (gi = 0; gi < 2; gi++) begin : g_lp
        lp_state_t       state_reg;
        lp_state_t       state_next;
        logic [LP_W-1:0] cnt_reg;
        logic            pressed;
        logic            fire;

        assign pressed = stable[RESET_IDX + gi];

        // State register and hold counter
        always_ff @(posedge clk) begin
            if (rst) begin
                state_reg <= LP_IDLE;
                cnt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                if (state_reg == LP_COUNT && pressed && cnt_reg != LP_LAST) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end else begin
                    cnt_reg <= '0;
                end
            end
        end

        // Next-state: one fire per hold, re-armed only by a release
        always_comb begin
            state_next = state_reg;
            case (state_reg)
                LP_IDLE:  if (pressed) state_next = LP_COUNT;
                LP_COUNT: begin
                    if (!pressed)                state_next = LP_IDLE;
                    else if (cnt_reg == LP_LAST) state_next = LP_FIRED;
                end
                LP_FIRED: if (!pressed) state_next = LP_IDLE;
                default:  state_next = LP_IDLE;
            endcase
        end

        // Fire on the terminal count of an uninterrupted hold
        always_comb begin
            fire = 1'b0;
            if (state_reg == LP_COUNT && pressed && cnt_reg == LP_LAST) begin
                fire = 1'b1;
            end
        end

        assign lp_fire[gi] = fire;
    end

    // Registered outputs; reset wins over test when both fire together
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev_reg <= '0;
            act_pulse_reg   <= '0;
            btn_reset_reg   <= 1'b0;
            btn_test_reg    <= 1'b0;
            ledsign_reg     <= 1'b0;
        end else begin
            stable_prev_reg <= stable[N_ACTION-1:0];
            act_pulse_reg   <= act_grant;
            btn_reset_reg   <= lp_fire[0];
            btn_test_reg    <= lp_fire[1] & ~lp_fire[0];
            ledsign_reg     <= stable[LIGHT_IDX];
        end
    end

    assign btn_salud     = act_pulse_reg[SALUD];
    assign btn_energia   = act_pulse_reg[ENERGIA];
    assign btn_hambre    = act_pulse_reg[HAMBRE];
    assign btn_diversion = act_pulse_reg[DIVERSION];
    assign btn_reset     = btn_reset_reg;
    assign btn_test      = btn_test_reg;
    assign ledsign       = ledsign_reg;

endmodule
